// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// Four-digit BCD up/down counter with a time-multiplexed digit scanner that
// feeds a 7447-style BCD-to-seven-segment decoder. Each scan slot presents one
// digit's BCD code and drives the matching active-low digit select. Blanked
// digits are presented as 4'b1111, which the decoder renders dark.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays selected (1..65535)
//   LZ_BLANK  1 = blank leading zeros, 0 = always show all four digits
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   countEn    in   one count step per clock while high
//   upDown     in   1 = increment, 0 = decrement
//   load       in   synchronous load of loadValue (priority over countEn)
//   loadValue  in   four BCD nibbles, [3:0] = least-significant digit
//   count      out  registered BCD count, [3:0] = least-significant digit
//   carry      out  registered one-cycle pulse on wrap in either direction
//   digitBcd   out  BCD code of the scanned digit, 4'b1111 when blanked
//   digitSel   out  active-low one-cold digit select, bit i selects digit i
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        countEn,
    input  logic        upDown,
    input  logic        load,
    input  logic [15:0] loadValue,
    output logic [15:0] count,
    output logic        carry,
    output logic [3:0]  digitBcd,
    output logic [3:0]  digitSel
);

    localparam logic [15:0] PRESCALE_LAST = 16'(SCAN_DIV - 32'd1);

    // Clamp every nibble above 9 down to 9 so the count never holds a non-BCD digit.
    function automatic logic [15:0] clampBcd(input logic [15:0] value);
        logic [15:0] result;
        result = value;
        for (int i = 0; i < 4; i++) begin
            if (value[i*4 +: 4] > 4'd9) begin
                result[i*4 +: 4] = 4'd9;
            end else begin
                result[i*4 +: 4] = value[i*4 +: 4];
            end
        end
        return result;
    endfunction

    // One BCD step with ripple; bit 16 of the result is set when all four
    // digits rippled, i.e. the counter wrapped 9999->0000 or 0000->9999.
    function automatic logic [16:0] bcdStep(input logic [15:0] value, input logic up);
        logic [15:0] result;
        logic        ripple;
        logic [3:0]  digit;
        result = value;
        ripple = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit = value[i*4 +: 4];
            if (ripple) begin
                if (up) begin
                    if (digit == 4'd9) begin
                        result[i*4 +: 4] = 4'd0;
                    end else begin
                        result[i*4 +: 4] = digit + 4'd1;
                        ripple           = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        result[i*4 +: 4] = 4'd9;
                    end else begin
                        result[i*4 +: 4] = digit - 4'd1;
                        ripple           = 1'b0;
                    end
                end
            end else begin
                result[i*4 +: 4] = digit;
            end
        end
        return {ripple, result};
    endfunction

    logic [15:0] count_r;
    logic        carry_r;
    logic [15:0] nextCount_s;
    logic        nextCarry_s;
    logic [16:0] stepResult_s;

    logic [15:0] prescale_r;
    logic [1:0]  scanIdx_r;
    logic [3:0]  digitSel_r;

    logic [3:0]  curDigit_s;
    logic [3:0]  blank_s;

    // Next count/carry: load beats counting, idle holds and clears carry.
    always_comb begin
        nextCount_s  = count_r;
        nextCarry_s  = 1'b0;
        stepResult_s = bcdStep(count_r, upDown);
        if (load) begin
            nextCount_s = clampBcd(loadValue);
            nextCarry_s = 1'b0;
        end else if (countEn) begin
            nextCount_s = stepResult_s[15:0];
            nextCarry_s = stepResult_s[16];
        end else begin
            nextCount_s = count_r;
            nextCarry_s = 1'b0;
        end
    end

    // Count and carry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'h0000;
            carry_r <= 1'b0;
        end else begin
            count_r <= nextCount_s;
            carry_r <= nextCarry_s;
        end
    end

    // Free-running prescaler and scan index; the select pattern is kept as a
    // rotating one-cold register so it always equals ~(1 << scanIdx_r).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_r <= 16'd0;
            scanIdx_r  <= 2'd0;
            digitSel_r <= 4'b1110;
        end else if (prescale_r == PRESCALE_LAST) begin
            prescale_r <= 16'd0;
            scanIdx_r  <= scanIdx_r + 2'd1;
            digitSel_r <= {digitSel_r[2:0], digitSel_r[3]};
        end else begin
            prescale_r <= prescale_r + 16'd1;
            scanIdx_r  <= scanIdx_r;
            digitSel_r <= digitSel_r;
        end
    end

    // Leading-zero mask: digit i blanks when it and all higher digits are zero.
    // Digit 0 is never blanked so a zero count still shows one "0".
    always_comb begin
        blank_s    = 4'b0000;
        blank_s[3] = LZ_BLANK && (count_r[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (count_r[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (count_r[7:4] == 4'd0);
        blank_s[0] = 1'b0;
    end

    // Digit presented to the decoder, taken straight from the live count.
    always_comb begin
        curDigit_s = 4'h0;
        digitBcd   = 4'h0;
        case (scanIdx_r)
            2'd0:    curDigit_s = count_r[3:0];
            2'd1:    curDigit_s = count_r[7:4];
            2'd2:    curDigit_s = count_r[11:8];
            2'd3:    curDigit_s = count_r[15:12];
            default: curDigit_s = 4'h0;
        endcase
        if (blank_s[scanIdx_r]) begin
            digitBcd = 4'b1111;
        end else begin
            digitBcd = curDigit_s;
        end
    end

    assign count    = count_r;
    assign carry    = carry_r;
    assign digitSel = digitSel_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
//
// Self-checking bench for bcd_scan_counter. Two instances share all inputs:
// one with leading-zero blanking, one without, both with SCAN_DIV = 4. The
// reference model keeps the count as a plain integer 0..9999 and derives the
// scanned digit from elapsed clock edges and decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic        countEn;
    logic        upDown;
    logic        load;
    logic [15:0] loadValue;

    logic [15:0] countA;
    logic        carryA;
    logic [3:0]  digitBcdA;
    logic [3:0]  digitSelA;

    logic [15:0] countB;
    logic        carryB;
    logic [3:0]  digitBcdB;
    logic [3:0]  digitSelB;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int modelN     = 0;
    bit modelCarry = 1'b0;
    int modelTicks = 0;

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dutLz (
        .clk       (clk),
        .rst       (rst),
        .countEn   (countEn),
        .upDown    (upDown),
        .load      (load),
        .loadValue (loadValue),
        .count     (countA),
        .carry     (carryA),
        .digitBcd  (digitBcdA),
        .digitSel  (digitSelA)
    );

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b0)) dutNoLz (
        .clk       (clk),
        .rst       (rst),
        .countEn   (countEn),
        .upDown    (upDown),
        .load      (load),
        .loadValue (loadValue),
        .count     (countB),
        .carry     (carryB),
        .digitBcd  (digitBcdB),
        .digitSel  (digitSelB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] toBcd(input int n);
        logic [15:0] r;
        r = 16'h0000;
        for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'((n / pow10(j)) % 10);
        return r;
    endfunction

    // Decimal value of a possibly non-BCD load word, each nibble capped at 9.
    function automatic int clampValue(input logic [15:0] v);
        int n;
        int d;
        n = 0;
        for (int j = 0; j < 4; j++) begin
            d = int'(v[j*4 +: 4]);
            if (d > 9) d = 9;
            n = n + d * pow10(j);
        end
        return n;
    endfunction

    function automatic logic [3:0] expDigit(input int n, input int idx, input bit lz);
        if (lz && idx >= 1 && n < pow10(idx)) return 4'hF;
        return 4'((n / pow10(idx)) % 10);
    endfunction

    task automatic checkAll(input string ctx);
        int          idx;
        logic [3:0]  one;
        logic [3:0]  sel;
        idx = (modelTicks / SCAN_DIV) % 4;
        one = 4'b0001;
        sel = ~(one << idx);
        checkVal({ctx, ".count"},     countA,    toBcd(modelN));
        checkVal({ctx, ".carry"},     {15'd0, carryA}, {15'd0, modelCarry});
        checkVal({ctx, ".digitSel"},  {12'd0, digitSelA}, {12'd0, sel});
        checkVal({ctx, ".digitBcd"},  {12'd0, digitBcdA}, {12'd0, expDigit(modelN, idx, 1'b1)});
        checkVal({ctx, ".countNoLz"}, countB,    toBcd(modelN));
        checkVal({ctx, ".digitNoLz"}, {12'd0, digitBcdB}, {12'd0, expDigit(modelN, idx, 1'b0)});
    endtask

    // Advance one clock: model consumes the current inputs, then outputs are compared.
    task automatic tick(input string ctx);
        int nNext;
        bit cNext;
        if (load) begin
            nNext = clampValue(loadValue);
            cNext = 1'b0;
        end else if (countEn) begin
            if (upDown) begin
                cNext = (modelN == 9999);
                nNext = (modelN + 1) % 10000;
            end else begin
                cNext = (modelN == 0);
                nNext = (modelN + 9999) % 10000;
            end
        end else begin
            nNext = modelN;
            cNext = 1'b0;
        end
        @(posedge clk);
        #1;
        modelN     = nNext;
        modelCarry = cNext;
        modelTicks++;
        checkAll(ctx);
    endtask

    task automatic drive(input bit l, input bit en, input bit up, input logic [15:0] v);
        load      = l;
        countEn   = en;
        upDown    = up;
        loadValue = v;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAll("reset");
        rst        = 1'b0;
        modelN     = 0;
        modelCarry = 1'b0;
        modelTicks = 0;

        // Ripple up and back down
        drive(1'b1, 1'b0, 1'b0, 16'h0099); tick("load0099");
        drive(1'b0, 1'b1, 1'b1, 16'h0000); tick("up0100");
        drive(1'b0, 1'b1, 1'b0, 16'h0000); tick("down0099");

        // Wrap up, then hold to see carry drop
        drive(1'b1, 1'b0, 1'b0, 16'h9999); tick("load9999");
        drive(1'b0, 1'b1, 1'b1, 16'h0000); tick("wrapUp");
        drive(1'b0, 1'b0, 1'b1, 16'h0000); tick("wrapUpHold");

        // Wrap down from 0000
        drive(1'b0, 1'b1, 1'b0, 16'h0000); tick("wrapDown");
        drive(1'b0, 1'b0, 1'b0, 16'h0000); tick("wrapDownHold");

        // Load priority over counting, with per-digit clamp
        drive(1'b1, 1'b1, 1'b1, 16'hA5F3); tick("loadClamp");

        // Scan patterns across two full frames each
        drive(1'b1, 1'b0, 1'b0, 16'h0042); tick("load0042");
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2 * 4 * SCAN_DIV; i++) tick("scan0042");
        drive(1'b1, 1'b0, 1'b0, 16'h0000); tick("load0000");
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2 * 4 * SCAN_DIV; i++) tick("scan0000");
        drive(1'b1, 1'b0, 1'b0, 16'h1000); tick("load1000");
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2 * 4 * SCAN_DIV; i++) tick("scan1000");

        // Randomized traffic, with loads biased toward wrap boundaries
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       v = 16'h9999;
                1:       v = 16'h0000;
                2:       v = 16'h9998;
                3:       v = 16'h0001;
                default: v = v;
            endcase
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), v);
            tick("random");
        end

        // Asynchronous reset in the middle of a count
        drive(1'b1, 1'b0, 1'b0, 16'h1234); tick("load1234");
        drive(1'b0, 1'b1, 1'b1, 16'h0000); tick("count1235");
        #2;
        rst = 1'b1;
        #1;
        modelN     = 0;
        modelCarry = 1'b0;
        modelTicks = 0;
        checkAll("asyncReset");
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 3 * SCAN_DIV; i++) tick("afterReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
